// File: rtl/pktgen_stream_checker.sv
// pktgen_stream_checker: receive-only AXI-Stream frame monitor with size/header capture, error flags, counters and windowed byte rate
// Optional payload comparator enabled by defining PKTGEN_CHK_PAYLOAD_EN
module pktgen_stream_checker #(
  parameter int DATA_WIDTH    = 512,
  parameter int CNT_WIDTH     = 32,
  parameter int WINDOW_CYCLES = 350000,
  parameter int MIN_SIZE      = 64,
  parameter int MAX_SIZE      = 1518
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [DATA_WIDTH-1:0]   axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] axis_tkeep,
  input  logic                    axis_tvalid,
  input  logic                    axis_tlast,
  input  logic                    clear,
  output logic [CNT_WIDTH-1:0]    frame_count,
  output logic [CNT_WIDTH-1:0]    byte_count,
  output logic [CNT_WIDTH-1:0]    err_count,
  output logic [10:0]             last_size,
  output logic [47:0]             last_d_mac,
  output logic [47:0]             last_s_mac,
  output logic [15:0]             last_ethertype,
  output logic                    frame_done,
  output logic                    frame_err,
  output logic [CNT_WIDTH-1:0]    rate_bytes,
  output logic                    rate_valid
);
  localparam int KW = DATA_WIDTH / 8;
  localparam int WW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [15:0] MIN_SZ = 16'(MIN_SIZE);
  localparam logic [15:0] MAX_SZ = 16'(MAX_SIZE);
  localparam logic [WW-1:0] WIN_LAST = WW'(WINDOW_CYCLES - 1);
  typedef enum logic {IDLE, BODY} state_t;
  state_t state_q;
  logic [15:0] size_q, size_d, pop, etype_q, etype_d;
  logic err_q, err_d, bad, pay_mis, keep_err, first, fend, win_end;
  logic [47:0] dmac_q, dmac_d, smac_q, smac_d, hd, hs;
  logic [CNT_WIDTH-1:0] fsize, frame_count_q, byte_count_q, err_count_q, acc_q, rate_bytes_q;
  logic [10:0] last_size_q;
  logic [47:0] last_d_mac_q, last_s_mac_q;
  logic [15:0] last_ethertype_q;
  logic frame_done_q, frame_err_q, rate_valid_q;
  logic [WW-1:0] win_q;
  // bytes contributed by this beat
  always_comb begin
    pop = '0;
    for (int k = 0; k < KW; k++) pop = pop + 16'(axis_tkeep[k]);
  end
  // header fields in network byte order from the first beat
  for (genvar g = 0; g < 6; g++) begin : g_hdr
    assign hd[47-8*g -: 8] = axis_tdata[8*g +: 8];
    assign hs[47-8*g -: 8] = axis_tdata[8*(g+6) +: 8];
  end
`ifdef PKTGEN_CHK_PAYLOAD_EN
  logic [7:0] ref_q, ref_b;
  logic [KW-1:0] neq;
  assign ref_b = first ? axis_tdata[119:112] : ref_q;
  for (genvar g = 0; g < KW; g++) begin : g_pay
    assign neq[g] = axis_tkeep[g] && (axis_tdata[8*g +: 8] != ref_b) && !(first && g < 15);
  end
  assign pay_mis = |neq;
  // reference payload byte held from the first beat for the rest of the frame
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ref_q <= '0;
    else if (first) ref_q <= ref_b;
`else
  logic unused_data;
  assign unused_data = ^axis_tdata[DATA_WIDTH-1:112];
  assign pay_mis = 1'b0;
`endif
  assign first    = axis_tvalid && state_q == IDLE;
  assign fend     = axis_tvalid && axis_tlast;
  assign size_d   = (state_q == BODY ? size_q : 16'd0) + pop;
  assign keep_err = axis_tlast ? |(axis_tkeep & (axis_tkeep + KW'(1))) : !(&axis_tkeep);
  assign err_d    = (state_q == BODY && err_q) || keep_err || (pay_mis && size_d > 16'd14);
  assign bad      = err_d || size_d < MIN_SZ || size_d > MAX_SZ;
  assign dmac_d   = first ? hd : dmac_q;
  assign smac_d   = first ? hs : smac_q;
  assign etype_d  = first ? {axis_tdata[103:96], axis_tdata[111:104]} : etype_q;
  assign fsize    = CNT_WIDTH'(size_d);
  assign win_end  = win_q == WIN_LAST;
  // frame assembly: state, running size, sticky error and captured header
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      size_q  <= '0;
      err_q   <= 1'b0;
      dmac_q  <= '0;
      smac_q  <= '0;
      etype_q <= '0;
    end else if (axis_tvalid) begin
      state_q <= axis_tlast ? IDLE : BODY;
      size_q  <= size_d;
      err_q   <= err_d;
      dmac_q  <= dmac_d;
      smac_q  <= smac_d;
      etype_q <= etype_d;
    end
  // frame completion: pulses, last-frame registers and counters; clear beats a coincident frame end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      frame_done_q     <= 1'b0;
      frame_err_q      <= 1'b0;
      last_size_q      <= '0;
      last_d_mac_q     <= '0;
      last_s_mac_q     <= '0;
      last_ethertype_q <= '0;
      frame_count_q    <= '0;
      byte_count_q     <= '0;
      err_count_q      <= '0;
    end else begin
      frame_done_q <= fend;
      frame_err_q  <= fend && bad;
      if (fend) begin
        last_size_q      <= size_d > 16'd2047 ? 11'h7ff : size_d[10:0];
        last_d_mac_q     <= dmac_d;
        last_s_mac_q     <= smac_d;
        last_ethertype_q <= etype_d;
      end
      if (clear) begin
        frame_count_q <= '0;
        byte_count_q  <= '0;
        err_count_q   <= '0;
      end else if (fend) begin
        frame_count_q <= frame_count_q + CNT_WIDTH'(1);
        byte_count_q  <= byte_count_q + fsize;
        err_count_q   <= err_count_q + CNT_WIDTH'(bad);
      end
    end
  // rate window: bytes of frames ending inside each window, published on its last cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      win_q        <= '0;
      acc_q        <= '0;
      rate_bytes_q <= '0;
      rate_valid_q <= 1'b0;
    end else begin
      rate_valid_q <= !clear && win_end;
      if (clear) begin
        win_q <= '0;
        acc_q <= '0;
      end else begin
        win_q <= win_end ? '0 : win_q + WW'(1);
        acc_q <= win_end ? '0 : acc_q + (fend ? fsize : '0);
        if (win_end) rate_bytes_q <= acc_q + (fend ? fsize : '0);
      end
    end
  assign frame_count    = frame_count_q;
  assign byte_count     = byte_count_q;
  assign err_count      = err_count_q;
  assign last_size      = last_size_q;
  assign last_d_mac     = last_d_mac_q;
  assign last_s_mac     = last_s_mac_q;
  assign last_ethertype = last_ethertype_q;
  assign frame_done     = frame_done_q;
  assign frame_err      = frame_err_q;
  assign rate_bytes     = rate_bytes_q;
  assign rate_valid     = rate_valid_q;
endmodule

// File: tb/tb_pktgen_stream_checker.sv
// tb_pktgen_stream_checker: table, directed and random checks of pktgen_stream_checker against a frame-level model
module tb_pktgen_stream_checker;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int WIN = 100;
`ifdef PKTGEN_CHK_PAYLOAD_EN
  localparam bit PAY = 1'b1;
`else
  localparam bit PAY = 1'b0;
`endif
  logic clk, rst_n, axis_tvalid, axis_tlast, clear;
  logic [DW-1:0] axis_tdata;
  logic [KW-1:0] axis_tkeep;
  logic [31:0] frame_count, byte_count, err_count, rate_bytes;
  logic [10:0] last_size;
  logic [47:0] last_d_mac, last_s_mac;
  logic [15:0] last_ethertype;
  logic frame_done, frame_err, rate_valid;
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit gaps = 0;
  pktgen_stream_checker #(.DATA_WIDTH(DW), .CNT_WIDTH(32), .WINDOW_CYCLES(WIN), .MIN_SIZE(64), .MAX_SIZE(1518)) dut (
    .clk(clk), .rst_n(rst_n), .axis_tdata(axis_tdata), .axis_tkeep(axis_tkeep),
    .axis_tvalid(axis_tvalid), .axis_tlast(axis_tlast), .clear(clear),
    .frame_count(frame_count), .byte_count(byte_count), .err_count(err_count),
    .last_size(last_size), .last_d_mac(last_d_mac), .last_s_mac(last_s_mac),
    .last_ethertype(last_ethertype), .frame_done(frame_done), .frame_err(frame_err),
    .rate_bytes(rate_bytes), .rate_valid(rate_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
    $fatal(1);
  end
  // frame-level reference model state
  logic [7:0] fq[$];
  logic [DW-1:0] hdr;
  bit bad, in_frame;
  int wcyc;
  logic [31:0] wsum, e_fc, e_bc, e_ec, e_rb;
  logic [10:0] e_ls;
  logic [47:0] e_dm, e_sm;
  logic [15:0] e_et;
  bit e_fd, e_fe, e_rv;
  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  task automatic model_reset();
    fq.delete();
    in_frame = 0; bad = 0; wcyc = 0; wsum = 0;
    e_fc = 0; e_bc = 0; e_ec = 0; e_rb = 0; e_ls = 0; e_dm = 0; e_sm = 0; e_et = 0;
    e_fd = 0; e_fe = 0; e_rv = 0;
  endtask
  task automatic model(bit v, logic [DW-1:0] d, logic [KW-1:0] k, bit l, bit c);
    int sz, n;
    bit ended, err, pbad, contig;
    ended = 0; sz = 0; err = 0;
    e_fd = 0; e_fe = 0; e_rv = 0;
    if (v) begin
      if (!in_frame) begin fq.delete(); hdr = d; bad = 0; end
      n = 0;
      for (int i = 0; i < KW; i++) if (k[i]) begin fq.push_back(d[8*i +: 8]); n++; end
      contig = 1;
      for (int i = 0; i < KW; i++) if (k[i] != (i < n)) contig = 0;
      if (!l && n != KW) bad = 1;
      if (l && !contig) bad = 1;
      in_frame = !l;
      if (l) begin
        sz = fq.size();
        ended = 1;
        pbad = 0;
        if (PAY && sz > 14) for (int i = 15; i < sz; i++) if (fq[i] != fq[14]) pbad = 1;
        err = bad || pbad || sz < 64 || sz > 1518;
        e_fd = 1;
        e_fe = err;
        e_ls = sz > 2047 ? 11'd2047 : 11'(sz);
        for (int i = 0; i < 6; i++) begin
          e_dm = {e_dm[39:0], hdr[8*i +: 8]};
          e_sm = {e_sm[39:0], hdr[8*(i+6) +: 8]};
        end
        e_et = {hdr[103:96], hdr[111:104]};
      end
    end
    if (c) begin
      e_fc = 0; e_bc = 0; e_ec = 0; wcyc = 0; wsum = 0;
    end else begin
      if (ended) begin
        e_fc += 1;
        e_bc += 32'(sz);
        if (err) e_ec += 1;
        wsum += 32'(sz);
      end
      if (wcyc == WIN - 1) begin e_rb = wsum; e_rv = 1; wsum = 0; wcyc = 0; end
      else wcyc++;
    end
  endtask
  task automatic compare_all();
    chk("frame_count", 64'(frame_count), 64'(e_fc));
    chk("byte_count", 64'(byte_count), 64'(e_bc));
    chk("err_count", 64'(err_count), 64'(e_ec));
    chk("last_size", 64'(last_size), 64'(e_ls));
    chk("last_d_mac", 64'(last_d_mac), 64'(e_dm));
    chk("last_s_mac", 64'(last_s_mac), 64'(e_sm));
    chk("last_ethertype", 64'(last_ethertype), 64'(e_et));
    chk("frame_done", 64'(frame_done), 64'(e_fd));
    chk("frame_err", 64'(frame_err), 64'(e_fe));
    chk("rate_bytes", 64'(rate_bytes), 64'(e_rb));
    chk("rate_valid", 64'(rate_valid), 64'(e_rv));
  endtask
  // drive one cycle at the falling edge, predict, then check after the next rising edge
  task automatic step(bit v, logic [DW-1:0] d, logic [KW-1:0] k, bit l, bit c);
    axis_tvalid = v; axis_tdata = d; axis_tkeep = k; axis_tlast = l; clear = c;
    model(v, d, k, l, c);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask
  task automatic check_zero(string nm);
    chk({nm, "_frame_count"}, 64'(frame_count), 64'd0);
    chk({nm, "_byte_count"}, 64'(byte_count), 64'd0);
    chk({nm, "_err_count"}, 64'(err_count), 64'd0);
    chk({nm, "_last_size"}, 64'(last_size), 64'd0);
    chk({nm, "_last_d_mac"}, 64'(last_d_mac), 64'd0);
    chk({nm, "_last_s_mac"}, 64'(last_s_mac), 64'd0);
    chk({nm, "_last_ethertype"}, 64'(last_ethertype), 64'd0);
    chk({nm, "_frame_done"}, 64'(frame_done), 64'd0);
    chk({nm, "_frame_err"}, 64'(frame_err), 64'd0);
    chk({nm, "_rate_bytes"}, 64'(rate_bytes), 64'd0);
    chk({nm, "_rate_valid"}, 64'(rate_valid), 64'd0);
  endtask
  // assert reset at the current falling edge, hold it across one rising edge, release
  task automatic do_reset();
    rst_n = 1'b0;
    #1 check_zero("rst_async");
    @(negedge clk);
    check_zero("rst_held");
    axis_tvalid = 0; axis_tlast = 0; axis_tkeep = '0; axis_tdata = '0; clear = 0;
    rst_n = 1'b1;
    model_reset();
    cyc = 0;
  endtask
  function automatic logic [DW-1:0] mk_beat(int b, logic [7:0] fill, logic [47:0] dm, int cidx);
    logic [DW-1:0] d;
    logic [47:0] sm;
    int idx;
    sm = 48'h0200_0000_0002;
    for (int i = 0; i < KW; i++) begin
      idx = b * KW + i;
      if (idx < 6) d[8*i +: 8] = dm[47-8*idx -: 8];
      else if (idx < 12) d[8*i +: 8] = sm[47-8*(idx-6) -: 8];
      else if (idx == 12) d[8*i +: 8] = 8'h08;
      else if (idx == 13) d[8*i +: 8] = 8'h00;
      else d[8*i +: 8] = (idx == cidx) ? ~fill : fill;
    end
    return d;
  endfunction
  // mode 1: first beat of a multi-beat frame drops its top byte; mode 2: last beat keep has a hole at bit 1
  task automatic send_frame(int nb, int nl, logic [7:0] fill, logic [47:0] dm, int cidx, int mode, bit clr_last);
    logic [KW-1:0] k;
    for (int b = 0; b < nb; b++) begin
      k = '1;
      if (b == nb - 1) for (int i = 0; i < KW; i++) k[i] = (i < nl);
      if (mode == 1 && b == 0 && nb > 1) k[KW-1] = 1'b0;
      if (mode == 2 && b == nb - 1) k[1] = 1'b0;
      if (gaps && b > 0) while ($urandom_range(0, 3) == 0) step(0, '0, '0, 0, 0);
      step(1, mk_beat(b, fill, dm, cidx), k, b == nb - 1, clr_last && b == nb - 1);
    end
  endtask
  typedef struct {
    int nb;
    int nl;
    int cidx;
    int mode;
    int exp_ls;
    bit exp_err;
  } vec_t;
  vec_t tbl[14];
  initial begin
    int nb, nl, mode, sz, cidx, r;
    tbl[0]  = '{1, 64, -1, 0, 64, 0};
    tbl[1]  = '{1, 63, -1, 0, 63, 1};
    tbl[2]  = '{1, 60, -1, 0, 60, 1};
    tbl[3]  = '{1, 14, -1, 0, 14, 1};
    tbl[4]  = '{3, 64, -1, 0, 192, 0};
    tbl[5]  = '{24, 46, -1, 0, 1518, 0};
    tbl[6]  = '{24, 47, -1, 0, 1519, 1};
    tbl[7]  = '{33, 64, -1, 0, 2047, 1};
    tbl[8]  = '{3, 64, -1, 1, 191, 1};
    tbl[9]  = '{2, 40, -1, 2, 103, 1};
    tbl[10] = '{3, 64, 100, 0, 192, PAY};
    tbl[11] = '{1, 20, 15, 0, 20, 1};
    tbl[12] = '{2, 1, -1, 0, 65, 0};
    tbl[13] = '{2, 16, 79, 0, 80, PAY};
    rst_n = 1'b0; axis_tvalid = 0; axis_tlast = 0; axis_tkeep = '0; axis_tdata = '0; clear = 0;
    @(negedge clk);
    do_reset();
    // single good 192-byte frame
    send_frame(3, 64, 8'hAA, 48'hABCDEF000001, -1, 0, 0);
    chk("t1_frame_done", 64'(frame_done), 64'd1);
    chk("t1_frame_err", 64'(frame_err), 64'd0);
    chk("t1_frame_count", 64'(frame_count), 64'd1);
    chk("t1_byte_count", 64'(byte_count), 64'd192);
    chk("t1_last_size", 64'(last_size), 64'd192);
    chk("t1_last_d_mac", 64'(last_d_mac), 64'hABCDEF000001);
    chk("t1_last_s_mac", 64'(last_s_mac), 64'h020000000002);
    chk("t1_last_ethertype", 64'(last_ethertype), 64'h0800);
    step(0, '0, '0, 0, 0);
    chk("t1_done_one_cycle", 64'(frame_done), 64'd0);
    // runt single-beat frame
    do_reset();
    send_frame(1, 60, 8'hAA, 48'hABCDEF000002, -1, 0, 0);
    chk("t2_frame_err", 64'(frame_err), 64'd1);
    chk("t2_err_count", 64'(err_count), 64'd1);
    chk("t2_last_size", 64'(last_size), 64'd60);
    // payload corruption at byte 100
    do_reset();
    send_frame(3, 64, 8'hAA, 48'hABCDEF000003, 100, 0, 0);
    chk("t3_err_count", 64'(err_count), 64'(PAY));
    // rate window: four frames inside the first window, then an empty window
    do_reset();
    for (int i = 0; i < 4; i++) send_frame(3, 64, 8'hAA, 48'hABCDEF000004, -1, 0, 0);
    while (cyc < WIN - 1) step(0, '0, '0, 0, 0);
    chk("t4_rate_valid_early", 64'(rate_valid), 64'd0);
    step(0, '0, '0, 0, 0);
    chk("t4_rate_valid", 64'(rate_valid), 64'd1);
    chk("t4_rate_bytes", 64'(rate_bytes), 64'd768);
    while (cyc < 2 * WIN) step(0, '0, '0, 0, 0);
    chk("t4_rate_valid2", 64'(rate_valid), 64'd1);
    chk("t4_rate_bytes2", 64'(rate_bytes), 64'd0);
    // reset during beat 2 of 3, then a 128-byte frame
    step(1, mk_beat(0, 8'h11, 48'h111111111111, -1), '1, 0, 0);
    axis_tvalid = 1; axis_tdata = mk_beat(1, 8'h11, 48'h111111111111, -1); axis_tkeep = '1; axis_tlast = 0;
    do_reset();
    send_frame(2, 64, 8'h22, 48'h222222222222, -1, 0, 0);
    chk("t5_frame_count", 64'(frame_count), 64'd1);
    chk("t5_last_size", 64'(last_size), 64'd128);
    chk("t5_frame_err", 64'(frame_err), 64'd0);
    chk("t5_err_count", 64'(err_count), 64'd0);
    // clear coincident with frame end
    do_reset();
    send_frame(3, 64, 8'h33, 48'h333333333333, -1, 0, 1);
    chk("t6_frame_count", 64'(frame_count), 64'd0);
    chk("t6_byte_count", 64'(byte_count), 64'd0);
    send_frame(3, 64, 8'h44, 48'h444444444444, -1, 0, 0);
    chk("t6_next_frame_count", 64'(frame_count), 64'd1);
    chk("t6_next_byte_count", 64'(byte_count), 64'd192);
    // table of size, keep and payload boundaries
    for (int t = 0; t < 14; t++) begin
      send_frame(tbl[t].nb, tbl[t].nl, 8'hA5, 48'h0A0B0C0D0E00 + 48'(t), tbl[t].cidx, tbl[t].mode, 0);
      chk($sformatf("tbl%0d_frame_done", t), 64'(frame_done), 64'd1);
      chk($sformatf("tbl%0d_last_size", t), 64'(last_size), 64'(tbl[t].exp_ls));
      chk($sformatf("tbl%0d_frame_err", t), 64'(frame_err), 64'(tbl[t].exp_err));
    end
    // random frames with mid-frame gaps and occasional clears
    gaps = 1;
    for (int f = 0; f < 250; f++) begin
      nb = $urandom_range(1, 25);
      nl = $urandom_range(1, 64);
      r = $urandom_range(0, 9);
      mode = (r == 0 && nb > 1) ? 1 : (r == 1 && nl >= 3) ? 2 : 0;
      sz = (nb - 1) * KW + nl;
      cidx = ($urandom_range(0, 3) == 0 && sz > 15) ? int'($urandom_range(15, sz - 1)) : -1;
      send_frame(nb, nl, 8'($urandom), 48'({$urandom, $urandom}), cidx, mode, $urandom_range(0, 29) == 0);
      repeat ($urandom_range(0, 2)) step(0, '0, '0, 0, $urandom_range(0, 49) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pktgen_stream_checker.md
# pktgen_stream_checker

Receive-only AXI-Stream monitor placed directly downstream of the packet generator's output stream. It accepts one beat per cycle with no backpressure, which matches the generator, since the generator has no `tready`. For each frame it reconstructs the MAC frame size and captures the Ethernet header. It flags malformed frames and keeps running frame, byte and error counters plus a windowed byte-rate measurement, so the configured flow bandwidths can be checked in hardware.

## Interface
Parameters:
- `DATA_WIDTH`, 512: stream width in bits. Multiple of 8 and ≥128, so the 14-byte header always lies in the first beat.
- `CNT_WIDTH`, 32: width of the frame, byte, error and rate counters.
- `WINDOW_CYCLES`, 350000: rate window length in `clk` cycles (1 ms at 350 MHz).
- `MIN_SIZE`, 64: smallest legal frame, in bytes.
- `MAX_SIZE`, 1518: largest legal frame, in bytes.

Ports:
- `clk`, in, 1: the single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `axis_tdata`, in, `DATA_WIDTH`: stream data. Byte k is `tdata[8k+7:8k]`.
- `axis_tkeep`, in, `DATA_WIDTH/8`: byte enables.
- `axis_tvalid`, in, 1: beat present.
- `axis_tlast`, in, 1: last beat of the frame.
- `clear`, in, 1: synchronous clear of all counters and of the rate window.
- `frame_count`, out, `CNT_WIDTH`: frames completed.
- `byte_count`, out, `CNT_WIDTH`: sum of all frame sizes.
- `err_count`, out, `CNT_WIDTH`: frames with at least one error.
- `last_size`, out, 11: size of the last frame, saturating at 2047.
- `last_d_mac`, out, 48: destination MAC of the last frame.
- `last_s_mac`, out, 48: source MAC of the last frame.
- `last_ethertype`, out, 16: ethertype of the last frame.
- `frame_done`, out, 1: one-cycle pulse when a frame completes.
- `frame_err`, out, 1: one-cycle pulse, coincident with `frame_done`, when that frame had an error.
- `rate_bytes`, out, `CNT_WIDTH`: bytes counted in the last completed window.
- `rate_valid`, out, 1: one-cycle pulse when `rate_bytes` updates.

## Operation
- FSM has two states, IDLE and BODY.
  - IDLE: a valid beat with `tlast`=1 is a single-beat frame; stay in IDLE.
  - IDLE: a valid beat with `tlast`=0 is a first beat; go to BODY.
  - BODY: a valid beat with `tlast`=1 ends the frame; go to IDLE.
  - Cycles with `tvalid` low never change state and are legal mid-frame.
- Header: on the first beat, capture the following (network byte order, byte 0 = MSB):
  - bytes 0–5 as d_mac;
  - bytes 6–11 as s_mac;
  - bytes 12–13 as ethertype.
- Frame size is accumulated per beat as popcount(`tkeep`) in a 16-bit accumulator.
- A frame is errored if any of the following holds:
  - size < `MIN_SIZE`;
  - size > `MAX_SIZE`;
  - any non-last beat has `tkeep` not all ones;
  - the last beat's `tkeep` is not contiguous from bit 0;
  - a payload mismatch is detected (see Configuration).
- On frame end:
  - `frame_count` += 1;
  - `byte_count` += size;
  - if errored, `err_count` += 1;
  - `last_*` registers are updated.
- All counters wrap modulo 2^`CNT_WIDTH`.
- Rate window:
  - a free-running cycle counter runs from 0 to `WINDOW_CYCLES`-1;
  - the size of each frame ending inside the window is added to the window accumulator;
  - at the last cycle of the window, `rate_bytes` is set to the accumulator (including any frame ending that same cycle), the accumulator restarts at 0, and `rate_valid` pulses.
- `clear`:
  - zeroes `frame_count`, `byte_count`, `err_count`, the window accumulator and the window counter;
  - `clear` wins over a simultaneous frame end, so that frame is not counted;
  - `clear` does not reset the FSM: a frame in progress continues and is counted when it ends.
- Reset:
  - all outputs are 0, FSM is IDLE, accumulators are 0;
  - a reset mid-frame discards the partial frame, and the next valid beat is treated as a first beat.

## Timing
- Accepts one beat per cycle, every cycle, with no stall.
- Counters, `last_*`, `frame_done` and `frame_err` update on the clock edge after the `tlast` beat is sampled (1-cycle latency).
- `rate_valid` is registered and asserts the cycle after the window counter reaches `WINDOW_CYCLES`-1.
- Back-to-back frames (a `tlast` beat followed immediately by the next first beat) are fully supported.

## Configuration
- `PKTGEN_CHK_PAYLOAD_EN` defined:
  - byte 14 of each frame is the reference payload byte;
  - every valid byte at index ≥15 must equal it, otherwise the frame is errored;
  - frames of size ≤14 bytes skip this check.
- `PKTGEN_CHK_PAYLOAD_EN` undefined:
  - the comparator logic is absent;
  - payload bytes never cause an error.

## Test plan
- Test 1, single good frame (`DATA_WIDTH`=512).
  - Stimulus: 192-byte frame, 3 beats with full `tkeep`, d_mac ABCDEF000001, payload 0xAA.
  - Response: one cycle after `tlast`, `frame_done`=1 and `frame_err`=0; `frame_count`=1, `byte_count`=192, `last_size`=192, `last_d_mac`=ABCDEF000001.
- Test 2, runt frame.
  - Stimulus: single-beat frame with `tkeep`=60 low ones.
  - Response: `frame_err` pulses, `err_count`=1, `last_size`=60.
- Test 3, payload corruption.
  - Stimulus: 192-byte frame with byte 100 set to 0x55.
  - Response with `PKTGEN_CHK_PAYLOAD_EN`: `err_count`=1. Without it: `err_count`=0.
- Test 4, rate window.
  - Stimulus: `WINDOW_CYCLES`=100; four 192-byte frames end within cycles 0–99.
  - Response: at cycle 100, `rate_valid` pulses and `rate_bytes`=768; next window with no traffic gives `rate_bytes`=0.
- Test 5, reset mid-frame.
  - Stimulus: drop `rst_n` during beat 2 of 3, then release and send a 128-byte 2-beat frame.
  - Response: all outputs 0 during reset, then `frame_count`=1, `last_size`=128, no error.
- Test 6, `clear` coincident with frame end.
  - Stimulus: assert `clear` on the cycle the `tlast` beat is sampled.
  - Response: `frame_count`=0 and `byte_count`=0 afterwards; the next frame gives `frame_count`=1.
